// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches from a combinational-read
// instruction memory, and queues {pc, instr} for decode with branch redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic        fetch_fault
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // pc_plus8 is stored per entry so every head output comes straight from a flop
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] instr;
    } entry_t;

    localparam entry_t EMPTY = '{valid: 1'b0, pc: 32'h0, pc8: 32'h8, instr: 32'h0};

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic          fault_q, fault_d;
    entry_t        q_q [DEPTH];
    entry_t        q_d [DEPTH];

    logic          legal;
    logic          pop;
    logic          push;
    logic [CW-1:0] wr_idx;

    assign legal = (pc_q[1:0] == 2'b00) && (pc_q[31:2] < 30'(IMEM_WORDS));
    assign pop   = q_q[0].valid && out_ready;
    assign push  = (state_q == RUN) && !br_valid && legal
                   && ((count_q < CW'(DEPTH)) || pop);

    // Head is always slot 0; a pop shifts the queue down one slot
    assign wr_idx = pop ? (count_q - CW'(1)) : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            fault_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_q[i] <= EMPTY;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        q_d     = q_q;

        if (br_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_d[i] = EMPTY;
            end
            count_d = '0;
            pc_d    = br_target;
            state_d = RUN;
        end else if ((state_q == RUN) && !legal) begin
            state_d = HALT;
            fault_d = 1'b1;
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    q_d[i] = q_q[i + 1];
                end
                q_d[DEPTH - 1] = EMPTY;
            end
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        q_d[i] = '{valid: 1'b1, pc: pc_q, pc8: pc_q + 32'd8, instr: imem_rd};
                    end
                end
                pc_d = pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign imem_a       = pc_q;
    assign out_valid    = q_q[0].valid;
    assign out_instr    = q_q[0].instr;
    assign out_pc       = q_q[0].pc;
    assign out_pc_plus8 = q_q[0].pc8;
    assign fetch_fault  = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the fetch stage.
module tb_fetch_stage;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned IMEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        br_valid;
    logic [31:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus8;
    logic        fetch_fault;

    logic [31:0] mem [IMEM_WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mhalt;
    bit          mfault;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(IMEM_WORDS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_plus8(out_pc_plus8),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_a[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] p);
        return (p[1:0] == 2'b00) && (p[31:2] < 30'(IMEM_WORDS));
    endfunction

    task automatic check_outputs();
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0].pc : 32'h0;
        e_instr = e_valid ? mq[0].instr : 32'h0;
        check("out_valid",    32'(out_valid),   32'(e_valid));
        check("out_pc",       out_pc,           e_pc);
        check("out_instr",    out_instr,        e_instr);
        check("out_pc_plus8", out_pc_plus8,     e_pc + 32'd8);
        check("fetch_fault",  32'(fetch_fault), 32'(mfault));
        check("imem_a",       imem_a,           mpc);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic cycle(input bit rst, input bit br, input logic [31:0] tgt, input bit rdy);
        bit pop;
        bit push;
        reset     = rst;
        br_valid  = br;
        br_target = tgt;
        out_ready = rdy;
        if (rst) begin
            mq.delete();
            mpc    = 32'h0;
            mhalt  = 1'b0;
            mfault = 1'b0;
        end else if (br) begin
            mq.delete();
            mpc   = tgt;
            mhalt = 1'b0;
        end else if (!mhalt && !is_legal(mpc)) begin
            mhalt  = 1'b1;
            mfault = 1'b1;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = !mhalt && is_legal(mpc) && ((mq.size() < int'(DEPTH)) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pc: mpc, instr: mem[mpc[7:2]]});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = 32'h100 + 32'(i);
        reset = 1'b1; br_valid = 1'b0; br_target = '0; out_ready = 1'b0;
        mq.delete(); mpc = '0; mhalt = 1'b0; mfault = 1'b0;

        // Reset state, then streaming with decode always ready
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run(6, 1'b1);

        // Backpressure: queue saturates, then drains in order
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run(5, 1'b0);
        run(4, 1'b1);

        // Redirect while full and popping
        run(3, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        run(3, 1'b1);

        // Run off the end of memory, drain, then redirect to 0
        cycle(1'b0, 1'b1, 32'hF0, 1'b0);
        run(6, 1'b0);
        run(4, 1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b1);
        run(3, 1'b1);

        // Misaligned target
        cycle(1'b0, 1'b1, 32'h6, 1'b1);
        run(3, 1'b1);

        // Reset with a full queue and fault set
        cycle(1'b0, 1'b1, 32'hF8, 1'b0);
        run(4, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        run(2, 1'b1);

        // Random traffic with random memory contents
        for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [31:0] tgt;
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 4))
                0, 1:    tgt = 32'($urandom_range(0, 63)) << 2;
                2:       tgt = 32'($urandom_range(60, 63)) << 2;
                3:       tgt = 32'($urandom_range(64, 70)) << 2;
                default: tgt = ($urandom & 32'hFF) | 32'h2;
            endcase
            cycle(r < 2, (r >= 2) && (r < 10), tgt, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
